pc_fetch_unit: RTL and testbench

Program-counter and instruction-fetch sequencer for the single-cycle CPU. It holds the PC and fetches each instruction from instruction memory over a req/ready handshake. It presents the instruction to the control unit and datapath for one execute cycle. In that cycle it samples the control unit's `PCWre`/`PCsrc` outputs and computes the next PC, or halts.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/npc_calc.sv | 30 +++
 rtl/pc_fetch_unit.sv | 113 +++++++++++
 tb/tb_pc_fetch_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch sequencer: word width, next-PC select
// encodings and the fetch FSM state type. The STEP state only exists when
// PC_SINGLE_STEP_EN is defined.
package cpu_pkg;

    localparam int WORD_W = 32;

    // Next-PC select encodings driven by the control unit (2'b11 is reserved)
    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

`ifdef PC_SINGLE_STEP_EN
    typedef enum logic [2:0] {
        ST_BOOT,
        ST_FETCH,
        ST_EXEC,
        ST_HALT,
        ST_STEP
    } fetch_state_t;
`else
    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_EXEC,
        ST_HALT
    } fetch_state_t;
`endif

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC mux: sequential, PC-relative branch and
// pseudo-direct jump targets. All sums wrap modulo 2^32.
module npc_calc
    import cpu_pkg::*;
(
    input  logic [WORD_W-1:0] pc,
    input  logic [1:0]        PCsrc,
    input  logic [WORD_W-1:0] imm_ext,
    input  logic [25:0]       jaddr,
    output logic [WORD_W-1:0] pc_plus4,
    output logic [WORD_W-1:0] npc
);

    logic signed [WORD_W-1:0] br_offset;

    assign pc_plus4  = pc + 32'd4;
    assign br_offset = $signed(imm_ext) <<< 2;

    // Select the next PC; the reserved encoding falls back to PC+4
    always_comb begin
        npc = pc_plus4;
        case (PCsrc)
            PCSRC_SEQ:    npc = pc_plus4;
            PCSRC_BRANCH: npc = pc_plus4 + $unsigned(br_offset);
            PCSRC_JUMP:   npc = {pc_plus4[31:28], jaddr, 2'b00};
            default:      npc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer for the single-cycle CPU.
// Fetches over a req/ready handshake, presents each instruction for one
// execute cycle, then advances the PC or halts.
// Optional feature macro: PC_SINGLE_STEP_EN (adds dbg_step_en / dbg_step and
// a STEP state that parks the sequencer after each executed instruction).
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              PCWre,
    input  logic [1:0]        PCsrc,
    input  logic [WORD_W-1:0] imm_ext,
    input  logic [25:0]       jaddr,
`ifdef PC_SINGLE_STEP_EN
    input  logic              dbg_step_en,
    input  logic              dbg_step,
`endif
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic [WORD_W-1:0] instr,
    output logic              instr_valid,
    output logic [WORD_W-1:0] pc,
    output logic              halted,
    output logic [WORD_W-1:0] retired
);

    localparam logic [WORD_W-1:0] RESET_PC_ALIGNED = {RESET_PC[WORD_W-1:2], 2'b00};

    fetch_state_t      state;
    logic [WORD_W-1:0] pc_plus4;
    logic [WORD_W-1:0] npc;

    npc_calc u_npc_calc (
        .pc       (pc),
        .PCsrc    (PCsrc),
        .imm_ext  (imm_ext),
        .jaddr    (jaddr),
        .pc_plus4 (pc_plus4),
        .npc      (npc)
    );

    // The fetch address is the PC register itself
    assign imem_addr = pc;

    // Fetch FSM with registered handshake, strobe and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_BOOT;
            pc          <= RESET_PC_ALIGNED;
            instr       <= '0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            halted      <= 1'b0;
            retired     <= '0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state    <= ST_FETCH;
                    imem_req <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_ready) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    instr_valid <= 1'b0;
                    retired     <= retired + 32'd1;
                    if (PCWre) begin
                        // Only branch and jump need the full mux; the
                        // sequential and reserved encodings both take PC+4
                        pc <= (PCsrc == PCSRC_BRANCH || PCsrc == PCSRC_JUMP) ? npc : pc_plus4;
`ifdef PC_SINGLE_STEP_EN
                        state    <= dbg_step_en ? ST_STEP : ST_FETCH;
                        imem_req <= !dbg_step_en;
`else
                        state    <= ST_FETCH;
                        imem_req <= 1'b1;
`endif
                    end else begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
`ifdef PC_SINGLE_STEP_EN
                ST_STEP: begin
                    if (dbg_step) begin
                        state    <= ST_FETCH;
                        imem_req <= 1'b1;
                    end
                end
`endif
                default: begin
                    state    <= ST_BOOT;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed programs are issued with
// their hand-computed execute-cycle PCs pushed to a queue; a monitor pops and
// compares on every instr_valid strobe.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        PCWre = 1'b0;
    logic [1:0]  PCsrc = 2'b00;
    logic [31:0] imm_ext = 32'h0;
    logic [25:0] jaddr = 26'h0;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic        halted;
    logic [31:0] retired;
`ifdef PC_SINGLE_STEP_EN
    logic        dbg_step_en = 1'b0;
    logic        dbg_step = 1'b0;
`endif

    pc_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .PCWre       (PCWre),
        .PCsrc       (PCsrc),
        .imm_ext     (imm_ext),
        .jaddr       (jaddr),
`ifdef PC_SINGLE_STEP_EN
        .dbg_step_en (dbg_step_en),
        .dbg_step    (dbg_step),
`endif
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .halted      (halted),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit step_mode = 1'b0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] ret;
    } exp_t;

    typedef struct {
        logic        wre;
        logic [1:0]  src;
        logic [31:0] imm;
        logic [25:0] ja;
        int          wt;
        logic [31:0] pc;
    } step_t;

    exp_t  sb_q[$];
    step_t prog[$];

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'hC0DE_5A5A;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    // Monitor: every execute strobe must match the next expected entry
    always @(negedge clk) begin : monitor
        exp_t e;
        if (instr_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid actual_pc=%h required=no_strobe", pc);
            end else begin
                e = sb_q.pop_front();
                check32("exec_pc", pc, e.pc);
                check32("exec_instr", instr, e.instr);
                check32("exec_retired", retired, e.ret);
            end
        end
    end

    task automatic add(input logic wre, input logic [1:0] src, input logic [31:0] imm,
                       input logic [25:0] ja, input int wt, input logic [31:0] epc);
        step_t s;
        s.wre = wre; s.src = src; s.imm = imm; s.ja = ja; s.wt = wt; s.pc = epc;
        prog.push_back(s);
    endtask

    // One-cycle reset, then check the BOOT cycle and the first request
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check32("rst_pc", pc, 32'h0);
        check32("rst_instr", instr, 32'h0);
        check1("rst_valid", instr_valid, 1'b0);
        check1("rst_req", imem_req, 1'b0);
        check1("rst_halted", halted, 1'b0);
        check32("rst_retired", retired, 32'h0);
        @(posedge clk); #1;
        check1("first_req", imem_req, 1'b1);
        check32("first_addr", imem_addr, 32'h0);
    endtask

    // Issue expected results, then serve fetches and drive execute controls
    task automatic run_program(input logic [31:0] ret0);
        exp_t e;
        int   n;
        logic [31:0] addr0;
        for (int i = 0; i < prog.size(); i++) begin
            e.pc = prog[i].pc; e.instr = mem_word(prog[i].pc); e.ret = ret0 + 32'(i);
            sb_q.push_back(e);
        end
        for (int i = 0; i < prog.size(); i++) begin
            if (i > 0) check1("back_to_back_req", imem_req, 1'b1);
            n = 0;
            while (imem_req !== 1'b1 && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            if (imem_req !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL req_timeout actual=0 required=1 step=%0d", i);
                break;
            end
            check32("fetch_addr", imem_addr, prog[i].pc);
            addr0 = imem_addr;
            for (int w = 0; w < prog[i].wt; w++) begin
                @(posedge clk); #1;
                check1("wait_req", imem_req, 1'b1);
                check32("wait_addr", imem_addr, addr0);
                check1("wait_valid", instr_valid, 1'b0);
            end
            imem_ready = 1'b1;
            imem_rdata = mem_word(imem_addr);
            @(posedge clk); #1;
            imem_ready = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            check1("exec_req_low", imem_req, 1'b0);
            PCWre = prog[i].wre; PCsrc = prog[i].src;
            imm_ext = prog[i].imm; jaddr = prog[i].ja;
            @(posedge clk); #1;
            // Junk controls outside EXEC must be ignored
            PCWre = 1'b1; PCsrc = 2'b01; imm_ext = 32'h0000_1234; jaddr = 26'h3FF_FFFF;
`ifdef PC_SINGLE_STEP_EN
            if (step_mode && prog[i].wre) begin
                for (int k = 0; k < 4; k++) begin
                    check1("step_hold_req", imem_req, 1'b0);
                    @(posedge clk); #1;
                end
                dbg_step = 1'b1;
                @(posedge clk); #1;
                dbg_step = 1'b0;
            end
`endif
        end
        prog.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Sequential program with a halt on the fourth instruction
        do_reset();
        add(1'b1, 2'b00, 32'h0, 26'h0, 0, 32'h0000_0000);
        add(1'b1, 2'b00, 32'h0, 26'h0, 0, 32'h0000_0004);
        add(1'b1, 2'b00, 32'h0, 26'h0, 0, 32'h0000_0008);
        add(1'b0, 2'b00, 32'h0, 26'h0, 0, 32'h0000_000C);
        run_program(32'd0);
        check1("halt_flag", halted, 1'b1);
        check1("halt_req", imem_req, 1'b0);
        check32("halt_retired", retired, 32'd4);
        check32("halt_pc", pc, 32'h0000_000C);
        repeat (3) @(posedge clk);
        #1;
        check1("halt_sticky", halted, 1'b1);
        check1("halt_req_sticky", imem_req, 1'b0);
        check32("halt_retired_sticky", retired, 32'd4);

        // Branches, jumps, reserved select, wrap-around and wait states
        do_reset();
        add(1'b1, 2'b00, 32'h0,         26'h0,  0, 32'h0000_0000);
        add(1'b1, 2'b01, 32'h1000_0000, 26'h0,  1, 32'h0000_0004);
        add(1'b1, 2'b10, 32'h0,         26'h40, 0, 32'h4000_0008);
        add(1'b1, 2'b01, 32'h2FFF_FFC7, 26'h0,  5, 32'h4000_0100);
        add(1'b1, 2'b11, 32'h0000_0100, 26'h0,  0, 32'h0000_0020);
        add(1'b1, 2'b01, 32'h3FFF_FFF5, 26'h0,  2, 32'h0000_0024);
        add(1'b1, 2'b00, 32'h0,         26'h0,  0, 32'hFFFF_FFFC);
        add(1'b1, 2'b10, 32'h0,         26'h4,  0, 32'h0000_0000);
        add(1'b1, 2'b01, 32'hFFFF_FFFF, 26'h0,  0, 32'h0000_0010);
        add(1'b1, 2'b01, 32'hFFFF_FFFC, 26'h0,  0, 32'h0000_0010);
        add(1'b0, 2'b00, 32'h0,         26'h0,  0, 32'h0000_0004);
        run_program(32'd0);
        check1("halt2_flag", halted, 1'b1);
        check32("halt2_retired", retired, 32'd11);

        // Reset while a fetch is waiting, with a response arriving alongside it
        do_reset();
        add(1'b1, 2'b00, 32'h0, 26'h0, 0, 32'h0000_0000);
        run_program(32'd0);
        check32("pre_rst_addr", imem_addr, 32'h0000_0004);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        reset = 1'b0;
        imem_ready = 1'b0;
        check1("abort_req", imem_req, 1'b0);
        check32("abort_pc", pc, 32'h0);
        check32("abort_retired", retired, 32'h0);
        check32("abort_instr", instr, 32'h0);
        check1("abort_valid", instr_valid, 1'b0);
        @(posedge clk); #1;
        check1("abort_refetch_req", imem_req, 1'b1);
        check1("abort_refetch_valid", instr_valid, 1'b0);
        add(1'b1, 2'b00, 32'h0, 26'h0, 0, 32'h0000_0000);
        add(1'b0, 2'b00, 32'h0, 26'h0, 0, 32'h0000_0004);
        run_program(32'd0);
        check32("abort_final_retired", retired, 32'd2);

`ifdef PC_SINGLE_STEP_EN
        // Single-step: park after each executed instruction until dbg_step
        dbg_step_en = 1'b1;
        step_mode = 1'b1;
        do_reset();
        add(1'b1, 2'b00, 32'h0, 26'h0, 0, 32'h0000_0000);
        add(1'b1, 2'b00, 32'h0, 26'h0, 0, 32'h0000_0004);
        add(1'b0, 2'b00, 32'h0, 26'h0, 0, 32'h0000_0008);
        run_program(32'd0);
        check32("step_retired", retired, 32'd3);
        check1("step_halted", halted, 1'b1);
        step_mode = 1'b0;
        dbg_step_en = 1'b0;
`endif

        repeat (2) @(posedge clk);
        #1;
        check32("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
